// File: rtl/pkt_pkg.sv
// Shared definitions for the cluster-protocol transmit path: packet codes,
// header layout constants, FSM encoding and the header byte selector.
package pkt_pkg;

   localparam logic [2:0] PKT_HB   = 3'd0;
   localparam logic [2:0] PKT_CHE  = 3'd1;
   localparam logic [2:0] PKT_INV  = 3'd2;
   localparam logic [2:0] PKT_MR   = 3'd3;
   localparam logic [2:0] PKT_CHTS = 3'd4;
   localparam logic [2:0] PKT_DATA = 3'd5;

   localparam int          HDR_LEN  = 6;
   localparam logic [15:0] BCAST_ID = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_FETCH = 3'd2,
      ST_PAY   = 3'd3,
      ST_CSUM  = 3'd4
   } tx_state_e;

   function automatic logic type_known(input logic [2:0] t);
      return (t <= PKT_DATA);
   endfunction

   // Header byte idx of the frame: type, src MSB/LSB, dest MSB/LSB, length.
   function automatic logic [7:0] hdr_byte(input logic [7:0]  idx,
                                           input logic [2:0]  t,
                                           input logic [15:0] src,
                                           input logic [15:0] dst,
                                           input logic [7:0]  len);
      logic [7:0] b;
      case (idx)
         8'd0:    b = {5'b00000, t};
         8'd1:    b = src[15:8];
         8'd2:    b = src[7:0];
         8'd3:    b = dst[15:8];
         8'd4:    b = dst[7:0];
         8'd5:    b = len;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/pkt_csum_acc.sv
// Running XOR checksum over the bytes of one outgoing frame.
module pkt_csum_acc
   import pkt_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] csum_o
);

   logic [W-1:0] acc_q;
   logic [W-1:0] acc_d;

   // Clear has priority so a new frame never inherits the previous sum.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q ^ data_i;
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign csum_o = acc_q;

endmodule

// File: rtl/pkt_transmitter.sv
// Frames HB/CHE/INV/MR/CHTS/DATA packets into a valid/ready byte stream,
// fetching payload bytes from the node's packet memory one at a time.
module pkt_transmitter
   import pkt_pkg::*;
#(
   parameter int WORD_WIDTH  = 16,
   parameter int MEM_WIDTH   = 8,
   parameter int MEM_DEPTH   = 2048,
   parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
   parameter int MAX_PAYLOAD = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            txPktType,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   input  logic [WORD_WIDTH-1:0] destinationID,
   input  logic [7:0]            txLen,
   input  logic [ADDR_WIDTH-1:0] txBaseAddr,
   output logic [ADDR_WIDTH-1:0] memAddr,
   output logic                  memRd,
   input  logic [MEM_WIDTH-1:0]  memData,
   output logic [MEM_WIDTH-1:0]  txByte,
   output logic                  txValid,
   input  logic                  txReady,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   tx_state_e             state_q, state_d;
   logic [7:0]            idx_q, idx_d;
   logic [2:0]            type_q, type_d;
   logic [WORD_WIDTH-1:0] src_q, src_d;
   logic [WORD_WIDTH-1:0] dst_q, dst_d;
   logic [7:0]            len_q, len_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [MEM_WIDTH-1:0]  pay_q, pay_d;
   logic                  hold_q, hold_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  csum_clr_s;
   logic                  csum_en_s;
   logic [MEM_WIDTH-1:0]  csum_s;
   logic [MEM_WIDTH-1:0]  hdr_byte_s;

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 8'd0;
         type_q  <= 3'd0;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= 8'd0;
         base_q  <= '0;
         pay_q   <= '0;
         hold_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         type_q  <= type_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         base_q  <= base_d;
         pay_q   <= pay_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      type_d     = type_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      base_d     = base_q;
      pay_d      = pay_q;
      hold_d     = hold_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      csum_clr_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (!type_known(txPktType) || (txLen > 8'(MAX_PAYLOAD))) begin
                  err_d = 1'b1;
               end else begin
                  type_d     = txPktType;
                  src_d      = myNodeID;
                  dst_d      = (txPktType == PKT_HB) ? WORD_WIDTH'(BCAST_ID) : destinationID;
                  len_d      = txLen;
                  base_d     = txBaseAddr;
                  idx_d      = 8'd0;
                  busy_d     = 1'b1;
                  csum_clr_s = 1'b1;
                  state_d    = ST_HDR;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (txReady) begin
               if (idx_q == 8'(HDR_LEN - 1)) begin
                  idx_d   = 8'd0;
                  state_d = (len_q == 8'd0) ? ST_CSUM : ST_FETCH;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_FETCH: begin
            hold_d  = 1'b0;
            state_d = ST_PAY;
         end
         ST_PAY: begin
            // Capture the read data once so the byte survives a stalled sink.
            if (!hold_q) begin
               pay_d  = memData;
               hold_d = 1'b1;
            end else begin
               pay_d = pay_q;
            end
            if (txReady) begin
               hold_d = 1'b0;
               if (idx_q == (len_q - 8'd1)) begin
                  state_d = ST_CSUM;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = ST_FETCH;
               end
            end else begin
               state_d = ST_PAY;
            end
         end
         ST_CSUM: begin
            if (txReady) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CSUM;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign hdr_byte_s = hdr_byte(idx_q, type_q, src_q, dst_q, len_q);

   // Stream and memory outputs decoded from the current state.
   always_comb begin
      txValid = 1'b0;
      txByte  = '0;
      memRd   = 1'b0;
      memAddr = '0;
      case (state_q)
         ST_HDR: begin
            txValid = 1'b1;
            txByte  = hdr_byte_s;
         end
         ST_FETCH: begin
            memRd   = 1'b1;
            memAddr = base_q + ADDR_WIDTH'(idx_q);
         end
         ST_PAY: begin
            txValid = 1'b1;
            txByte  = hold_q ? pay_q : memData;
         end
         ST_CSUM: begin
            txValid = 1'b1;
            txByte  = csum_s;
         end
         default: begin
            txValid = 1'b0;
         end
      endcase
   end

   assign csum_en_s = txValid & txReady & (state_q != ST_CSUM);

   pkt_csum_acc #(.W(MEM_WIDTH)) u_csum (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (csum_clr_s),
      .en_i   (csum_en_s),
      .data_i (txByte),
      .csum_o (csum_s)
   );

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_pkt_transmitter.sv
// Directed bench for pkt_transmitter: frame contents, backpressure, rejects,
// address wrap, mid-packet start and reset abort.
module tb_pkt_transmitter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  txPktType = 3'd0;
   logic [15:0] myNodeID = 16'h0000;
   logic [15:0] destinationID = 16'h0000;
   logic [7:0]  txLen = 8'd0;
   logic [10:0] txBaseAddr = 11'd0;
   logic [10:0] memAddr;
   logic        memRd;
   logic [7:0]  memData = 8'h00;
   logic [7:0]  txByte;
   logic        txValid;
   logic        txReady;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad = 0;

   logic [7:0]  mem [0:2047];
   logic [7:0]  stream [$];
   logic [10:0] rd_addr [$];
   logic [7:0]  exp_q [$];

   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int valid_cnt = 0;
   int stall_cycles = 0;
   int stall_bad = 0;
   int done_busy_bad = 0;
   int stalled_here = 0;
   int last_xfer_cyc = 0;
   int done_cyc = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_byte = 8'h00;
   logic       ready_base = 1'b1;
   logic       stall_mode = 1'b0;
   logic       stall_now = 1'b0;

   assign txReady = ready_base && !stall_now;

   pkt_transmitter dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .txPktType     (txPktType),
      .myNodeID      (myNodeID),
      .destinationID (destinationID),
      .txLen         (txLen),
      .txBaseAddr    (txBaseAddr),
      .memAddr       (memAddr),
      .memRd         (memRd),
      .memData       (memData),
      .txByte        (txByte),
      .txValid       (txValid),
      .txReady       (txReady),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   always #5 clk = ~clk;

   // Synchronous-read packet memory: data valid the cycle after memRd.
   always @(posedge clk) begin
      cyc++;
      if (memRd) memData <= mem[memAddr];
   end

   // Sink stalls for 3 cycles when byte B2 or byte B7 (payload BB) is offered.
   always @(posedge clk) begin
      #1;
      stall_now = stall_mode && (stream.size() == 2 || stream.size() == 7) && (stalled_here < 3);
   end

   // Stream monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (memRd) rd_addr.push_back(memAddr);
         if (txValid) valid_cnt++;
         if (prev_stall && (!txValid || txByte !== prev_byte || memRd)) stall_bad++;
         if (txValid && txReady) begin
            stream.push_back(txByte);
            last_xfer_cyc = cyc;
            stalled_here = 0;
         end else if (txValid) begin
            stalled_here++;
            stall_cycles++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) done_busy_bad++;
         end
         if (err) err_cnt++;
         prev_stall = txValid && !txReady;
         prev_byte  = txByte;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic clear_mon();
      stream.delete();
      rd_addr.delete();
      done_cnt = 0; err_cnt = 0; valid_cnt = 0;
      stall_cycles = 0; stall_bad = 0; done_busy_bad = 0; stalled_here = 0;
   endtask

   task automatic send(input logic [2:0] t, input logic [15:0] src, input logic [15:0] dst,
                       input logic [7:0] len, input logic [10:0] base);
      @(posedge clk); #1;
      txPktType = t; myNodeID = src; destinationID = dst; txLen = len; txBaseAddr = base;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      int n = 0;
      while (done_cnt == 0 && n < max_cyc) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (txValid !== 1'b0)  begin bad++; $display("FAIL rst_txValid got=%b want=0", txValid); end
      total++; if (txByte !== 8'h00)  begin bad++; $display("FAIL rst_txByte got=%h want=00", txByte); end
      total++; if (memRd !== 1'b0)    begin bad++; $display("FAIL rst_memRd got=%b want=0", memRd); end
      total++; if (memAddr !== 11'd0) begin bad++; $display("FAIL rst_memAddr got=%h want=000", memAddr); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done got=%b want=0", done); end
      total++; if (err !== 1'b0)      begin bad++; $display("FAIL rst_err got=%b want=0", err); end
      rst = 1'b0;
   endtask

   task automatic test_hb();
      clear_mon();
      send(3'd0, 16'h000C, 16'h0042, 8'd0, 11'h000);
      total++; if (busy !== 1'b1)    begin bad++; $display("FAIL hb_busy_after_accept got=%b want=1", busy); end
      total++; if (txValid !== 1'b1) begin bad++; $display("FAIL hb_b0_valid got=%b want=1", txValid); end
      total++; if (txByte !== 8'h00) begin bad++; $display("FAIL hb_b0_byte got=%h want=00", txByte); end
      wait_done(50);
      exp_q = '{8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h0C};
      total++; if (stream.size() != exp_q.size()) begin bad++; $display("FAIL hb_len got=%0d want=%0d", stream.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (i >= stream.size() || stream[i] !== exp_q[i]) begin
            bad++; $display("FAIL hb_byte%0d got=%h want=%h", i, (i < stream.size()) ? stream[i] : 8'hxx, exp_q[i]);
         end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL hb_done_cnt got=%0d want=1", done_cnt); end
      total++; if (done_cyc != last_xfer_cyc + 1) begin bad++; $display("FAIL hb_done_latency got=%0d want=%0d", done_cyc, last_xfer_cyc + 1); end
      total++; if (done_busy_bad != 0) begin bad++; $display("FAIL hb_busy_at_done got=%0d want=0", done_busy_bad); end
      total++; if (rd_addr.size() != 0) begin bad++; $display("FAIL hb_memrd got=%0d want=0", rd_addr.size()); end
   endtask

   task automatic run_data_pkt(input string tag, input logic stall);
      clear_mon();
      stall_mode = stall;
      send(3'd5, 16'h000C, 16'h000D, 8'd3, 11'h010);
      wait_done(100);
      stall_mode = 1'b0;
      exp_q = '{8'h05, 8'h00, 8'h0C, 8'h00, 8'h0D, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDA};
      total++; if (stream.size() != exp_q.size()) begin bad++; $display("FAIL %s_len got=%0d want=%0d", tag, stream.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (i >= stream.size() || stream[i] !== exp_q[i]) begin
            bad++; $display("FAIL %s_byte%0d got=%h want=%h", tag, i, (i < stream.size()) ? stream[i] : 8'hxx, exp_q[i]);
         end
      end
      total++; if (rd_addr.size() != 3) begin bad++; $display("FAIL %s_memrd_cnt got=%0d want=3", tag, rd_addr.size()); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (i >= rd_addr.size() || rd_addr[i] !== 11'(11'h010 + i)) begin
            bad++; $display("FAIL %s_memaddr%0d got=%h want=%h", tag, i, (i < rd_addr.size()) ? rd_addr[i] : 11'hxxx, 11'(11'h010 + i));
         end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done_cnt got=%0d want=1", tag, done_cnt); end
      total++; if (stall_bad != 0) begin bad++; $display("FAIL %s_hold_stable got=%0d want=0", tag, stall_bad); end
   endtask

   task automatic test_data();
      mem[11'h010] = 8'hAA; mem[11'h011] = 8'hBB; mem[11'h012] = 8'hCC;
      run_data_pkt("data", 1'b0);
      total++; if (stall_cycles != 0) begin bad++; $display("FAIL data_stalls got=%0d want=0", stall_cycles); end
   endtask

   task automatic test_back_pressure();
      run_data_pkt("bp", 1'b1);
      total++; if (stall_cycles != 6) begin bad++; $display("FAIL bp_stalls got=%0d want=6", stall_cycles); end
   endtask

   task automatic test_reject();
      clear_mon();
      send(3'd6, 16'h000C, 16'h000D, 8'd0, 11'h000);
      total++; if (err !== 1'b1)  begin bad++; $display("FAIL rej_type_err got=%b want=1", err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rej_type_busy got=%b want=0", busy); end
      send(3'd1, 16'h000C, 16'h000D, 8'd33, 11'h000);
      total++; if (err !== 1'b1)  begin bad++; $display("FAIL rej_len_err got=%b want=1", err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rej_len_busy got=%b want=0", busy); end
      repeat (5) @(posedge clk);
      #1;
      total++; if (err_cnt != 2)   begin bad++; $display("FAIL rej_err_pulses got=%0d want=2", err_cnt); end
      total++; if (valid_cnt != 0) begin bad++; $display("FAIL rej_valid_cycles got=%0d want=0", valid_cnt); end
      total++; if (done_cnt != 0)  begin bad++; $display("FAIL rej_done got=%0d want=0", done_cnt); end
      // Largest legal length (32) must be accepted; memory there is all zero.
      clear_mon();
      send(3'd3, 16'h000C, 16'h000D, 8'd32, 11'h100);
      total++; if (err !== 1'b0)  begin bad++; $display("FAIL max_len_err got=%b want=0", err); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL max_len_busy got=%b want=1", busy); end
      wait_done(200);
      total++; if (stream.size() != 39) begin bad++; $display("FAIL max_len_len got=%0d want=39", stream.size()); end
      total++; if (stream.size() == 0 || stream[stream.size()-1] !== 8'h22) begin
         bad++; $display("FAIL max_len_csum got=%h want=22", (stream.size() > 0) ? stream[stream.size()-1] : 8'hxx);
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL max_len_done got=%0d want=1", done_cnt); end
   endtask

   task automatic test_wrap();
      mem[11'h7FF] = 8'h5A; mem[11'h000] = 8'hA5;
      clear_mon();
      send(3'd5, 16'h000C, 16'h000D, 8'd2, 11'h7FF);
      repeat (2) @(posedge clk);
      #1;
      txPktType = 3'd0; myNodeID = 16'h1111; destinationID = 16'h2222; txLen = 8'd9; txBaseAddr = 11'h123;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(100);
      repeat (5) @(posedge clk);
      #1;
      exp_q = '{8'h05, 8'h00, 8'h0C, 8'h00, 8'h0D, 8'h02, 8'h5A, 8'hA5, 8'hF9};
      total++; if (stream.size() != exp_q.size()) begin bad++; $display("FAIL wrap_len got=%0d want=%0d", stream.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (i >= stream.size() || stream[i] !== exp_q[i]) begin
            bad++; $display("FAIL wrap_byte%0d got=%h want=%h", i, (i < stream.size()) ? stream[i] : 8'hxx, exp_q[i]);
         end
      end
      total++; if (rd_addr.size() != 2) begin bad++; $display("FAIL wrap_memrd_cnt got=%0d want=2", rd_addr.size()); end
      total++; if (rd_addr.size() < 1 || rd_addr[0] !== 11'h7FF) begin bad++; $display("FAIL wrap_addr0 got=%h want=7ff", (rd_addr.size() > 0) ? rd_addr[0] : 11'hxxx); end
      total++; if (rd_addr.size() < 2 || rd_addr[1] !== 11'h000) begin bad++; $display("FAIL wrap_addr1 got=%h want=000", (rd_addr.size() > 1) ? rd_addr[1] : 11'hxxx); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL wrap_done_cnt got=%0d want=1", done_cnt); end
      total++; if (err_cnt != 0)  begin bad++; $display("FAIL wrap_err got=%0d want=0", err_cnt); end
   endtask

   task automatic test_reset_abort();
      int n = 0;
      clear_mon();
      send(3'd5, 16'h000C, 16'h000D, 8'd3, 11'h010);
      while (stream.size() < 7 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #2;
      rst = 1'b1;
      #1;
      total++; if (txValid !== 1'b0)  begin bad++; $display("FAIL abort_txValid got=%b want=0", txValid); end
      total++; if (txByte !== 8'h00)  begin bad++; $display("FAIL abort_txByte got=%h want=00", txByte); end
      total++; if (memRd !== 1'b0)    begin bad++; $display("FAIL abort_memRd got=%b want=0", memRd); end
      total++; if (memAddr !== 11'd0) begin bad++; $display("FAIL abort_memAddr got=%h want=000", memAddr); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
      clear_mon();
      send(3'd1, 16'h000C, 16'h0042, 8'd0, 11'h000);
      wait_done(50);
      exp_q = '{8'h01, 8'h00, 8'h0C, 8'h00, 8'h42, 8'h00, 8'h4F};
      total++; if (stream.size() != exp_q.size()) begin bad++; $display("FAIL che_len got=%0d want=%0d", stream.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (i >= stream.size() || stream[i] !== exp_q[i]) begin
            bad++; $display("FAIL che_byte%0d got=%h want=%h", i, (i < stream.size()) ? stream[i] : 8'hxx, exp_q[i]);
         end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL che_done_cnt got=%0d want=1", done_cnt); end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      test_reset();
      test_hb();
      test_data();
      test_back_pressure();
      test_reject();
      test_wrap();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
